// File: rtl/sysref_align.sv
// SYSREF period checker and per-channel delayed re-launch into the fabric clock domain.
// Define SYSREF_FREEWHEEL_EN to keep issuing launches across missing SYSREF edges while locked.
module sysref_align #(
    parameter int NCH   = 4,
    parameter int CNTW  = 16,
    parameter int DLYW  = 4,
    parameter int LOCKN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sysref_in,
    input  logic                 arm,
    input  logic [CNTW-1:0]      period_cfg,
    input  logic [NCH*DLYW-1:0]  dly,
    output logic [NCH-1:0]       pl_sysref,
    output logic                 locked,
    output logic                 period_err,
    output logic [CNTW-1:0]      period_meas
);

    localparam int DEPTH = 2 ** DLYW;
    localparam int MW    = (LOCKN > 1) ? $clog2(LOCKN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        LOCKED
    } state_t;

    state_t                     state;
    logic   [1:0]               rst_sync;
    logic                       rst_int_n;
    logic                       s1, s2, s3;
    logic                       edge_det;
    logic   [CNTW-1:0]          cnt;
    logic                       at_cfg;
    logic                       cnt_sat;
    logic                       fw_tick;
    logic                       miss;
    logic                       launch;
    logic                       started;
    logic   [MW-1:0]            match_cnt;
    logic   [NCH-1:0][DEPTH-1:0] line;

    // Reset asserts immediately but releases only after two clk edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sysref_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;
    assign at_cfg   = (cnt == period_cfg);
    assign cnt_sat  = &cnt;

`ifdef SYSREF_FREEWHEEL_EN
    assign fw_tick = (state == LOCKED) && !edge_det && at_cfg;
    assign miss    = 1'b0;
`else
    logic at_miss;
    assign at_miss = (cnt == period_cfg + CNTW'(1));
    assign fw_tick = 1'b0;
    assign miss    = (state == LOCKED) && !edge_det && at_miss;
`endif

    // A free-wheel tick and a real edge at the same instant yield one launch.
    assign launch = (state == LOCKED) && ((edge_det && at_cfg) || fw_tick);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt <= '0;
        end else if (edge_det || fw_tick) begin
            cnt <= CNTW'(1);
        end else if (!cnt_sat) begin
            cnt <= cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= IDLE;
            started     <= 1'b0;
            match_cnt   <= '0;
            locked      <= 1'b0;
            period_err  <= 1'b0;
            period_meas <= '0;
        end else begin
            period_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= HUNT;
                        started   <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                HUNT: begin
                    if (edge_det) begin
                        if (!started) begin
                            started <= 1'b1;
                        end else begin
                            period_meas <= cnt;
                            if (!at_cfg) begin
                                match_cnt  <= '0;
                                period_err <= 1'b1;
                            end else if (match_cnt == MW'(LOCKN - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        period_meas <= cnt;
                        // The offending edge becomes the first edge of the new hunt.
                        if (!at_cfg) begin
                            period_err <= 1'b1;
                            locked     <= 1'b0;
                            state      <= HUNT;
                            started    <= 1'b1;
                            match_cnt  <= '0;
                        end
                    end else if (miss) begin
                        period_err <= 1'b1;
                        locked     <= 1'b0;
                        state      <= HUNT;
                        started    <= 1'b0;
                        match_cnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Each channel owns a full-depth line so overlapping launches never merge.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            line      <= '0;
            pl_sysref <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                line[i]      <= {line[i][DEPTH-2:0], launch};
                pl_sysref[i] <= line[i][dly[i*DLYW +: DLYW]];
            end
        end
    end

endmodule
